// File: rtl/alu_muldiv_if.sv
// Handshake and result bus of the iterative multiply/divide unit.
// The MTHI/MTLO write port exists only when ALU_MULDIV_HILO_WR_EN is defined.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
`ifdef ALU_MULDIV_HILO_WR_EN
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output start, opcode, a_input, b_input, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo, div_by_zero
  );
  modport slave (
    input  start, opcode, a_input, b_input, hi_we, lo_we, wr_data,
    output busy, done, hi, lo, div_by_zero
  );
`else
  modport master (
    output start, opcode, a_input, b_input,
    input  busy, done, hi, lo, div_by_zero
  );
  modport slave (
    input  start, opcode, a_input, b_input,
    output busy, done, hi, lo, div_by_zero
  );
`endif
endinterface

// File: rtl/alu_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit holding its result in HI/LO.
// Define ALU_MULDIV_HILO_WR_EN to add the MTHI/MTLO write port.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic               busy_r, busy_s, done_r, done_s;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               dbz_out_r;

  logic               is_div_r, sign_lo_r, sign_hi_r, dbz_r;
  logic [WIDTH-1:0]   a_raw_r, opnd_r;
  // Upper WIDTH+1 bits: partial product / partial remainder; lower WIDTH: multiplier / quotient.
  logic [2*WIDTH:0]   p_r, p_step_s;

  logic               signed_op_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_rem_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_out_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = bus.start ? RUN : IDLE;
      RUN:     state_s = (cnt_r == CW'(WIDTH - 1)) ? SIGN : RUN;
      SIGN:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode; busy/done are registered so they change exactly at the edge
  always_comb begin
    busy_s = (state_s != IDLE);
    done_s = (state_r == SIGN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Operand magnitudes and sign detection at launch
  always_comb begin
    signed_op_s = ~bus.opcode[0];
    a_neg_s     = signed_op_s & bus.a_input[WIDTH-1];
    b_neg_s     = signed_op_s & bus.b_input[WIDTH-1];
    a_mag_s     = a_neg_s ? -bus.a_input : bus.a_input;
    b_mag_s     = b_neg_s ? -bus.b_input : bus.b_input;
  end

  // One shift-add or restoring-divide step
  always_comb begin
    mul_sum_s  = p_r[2*WIDTH:WIDTH] + (p_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_rem_s  = {p_r[2*WIDTH-1:WIDTH], p_r[WIDTH-1]};
    div_diff_s = div_rem_s - {1'b0, opnd_r};
    if (is_div_r) begin
      if (div_rem_s >= {1'b0, opnd_r}) begin
        p_step_s = {div_diff_s, p_r[WIDTH-2:0], 1'b1};
      end else begin
        p_step_s = {div_rem_s, p_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      p_step_s = {1'b0, mul_sum_s, p_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override of the final result
  always_comb begin
    prod_s   = p_r[2*WIDTH-1:0];
    res_hi_s = p_r[2*WIDTH-1:WIDTH];
    res_lo_s = p_r[WIDTH-1:0];
    if (is_div_r) begin
      if (dbz_r) begin
        res_hi_s = a_raw_r;
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_lo_s = sign_lo_r ? -p_r[WIDTH-1:0] : p_r[WIDTH-1:0];
        res_hi_s = sign_hi_r ? -p_r[2*WIDTH-1:WIDTH] : p_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      prod_s   = sign_lo_r ? -p_r[2*WIDTH-1:0] : p_r[2*WIDTH-1:0];
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Datapath registers and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      sign_lo_r <= 1'b0;
      sign_hi_r <= 1'b0;
      dbz_r     <= 1'b0;
      a_raw_r   <= {WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      p_r       <= {(2*WIDTH+1){1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      dbz_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r     <= {CW{1'b0}};
            is_div_r  <= bus.opcode[1];
            sign_lo_r <= a_neg_s ^ b_neg_s;
            sign_hi_r <= bus.opcode[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
            dbz_r     <= bus.opcode[1] & (bus.b_input == {WIDTH{1'b0}});
            a_raw_r   <= bus.a_input;
            opnd_r    <= bus.opcode[1] ? b_mag_s : a_mag_s;
            p_r       <= {{(WIDTH+1){1'b0}}, (bus.opcode[1] ? a_mag_s : b_mag_s)};
          end
`ifdef ALU_MULDIV_HILO_WR_EN
          else begin
            if (bus.hi_we) hi_r <= bus.wr_data;
            if (bus.lo_we) lo_r <= bus.wr_data;
          end
`endif
        end
        RUN: begin
          p_r   <= p_step_s;
          cnt_r <= cnt_r + CW'(1'b1);
        end
        SIGN: begin
          hi_r      <= res_hi_s;
          lo_r      <= res_lo_s;
          dbz_out_r <= dbz_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, corner sequences
// and randomized operations against a plain-arithmetic reference model.
module tb_alu_muldiv;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, exp_hi, exp_lo;
    logic         exp_dbz;
  } vec_t;
  vec_t tbl [10];

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, b,
                                output logic [W-1:0] mh, ml, output logic md);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a};           ub = {32'd0, b};
    md = 1'b0; mh = '0; ml = '0;
    if (op[1] && b == 32'd0) begin
      mh = a; ml = 32'hFFFF_FFFF; md = 1'b1;
    end else begin
      case (op)
        2'b00: begin p  = sa * sb; mh = p[63:32];  ml = p[31:0];  end
        2'b01: begin up = ua * ub; mh = up[63:32]; ml = up[31:0]; end
        2'b10: begin q  = sa / sb; r = sa % sb; mh = r[31:0]; ml = q[31:0]; end
        default: begin uq = ua / ub; ur = ua % ub; mh = ur[31:0]; ml = uq[31:0]; end
      endcase
    end
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.a_input = a; bus.b_input = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a_input = $urandom; bus.b_input = $urandom;
  endtask

  // Returns cycles from the start edge to the done pulse; busy_ok reports protocol health.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = bus.busy;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
      if (bus.done && bus.busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int lat, n_done, first;
    logic bok, md;
    logic [W-1:0] mh, ml;
    logic [1:0] op;
    logic [W-1:0] a, b;

    tbl[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[2] = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    tbl[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[5] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
    tbl[7] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[9] = '{2'b11, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};

    rst_n = 1'b0; bus.start = 1'b0; bus.opcode = 2'b00;
    bus.a_input = 32'h1234_5678; bus.b_input = 32'h9ABC_DEF0;
`ifdef ALU_MULDIV_HILO_WR_EN
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors, issued back-to-back in the done cycle
    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(lat, bok);
      check($sformatf("vec%0d_lat", i), lat, LAT);
      check($sformatf("vec%0d_busy", i), bok, 1'b1);
      check($sformatf("vec%0d_hi", i), bus.hi, tbl[i].exp_hi);
      check($sformatf("vec%0d_lo", i), bus.lo, tbl[i].exp_lo);
      check($sformatf("vec%0d_dbz", i), bus.div_by_zero, tbl[i].exp_dbz);
    end

    // Results hold while idle
    repeat (5) begin
      @(negedge clk); bus.a_input = $urandom; bus.b_input = $urandom;
    end
    @(posedge clk); #1;
    check("hold_hi", bus.hi, 32'hFFFF_FFF0);
    check("hold_lo", bus.lo, 32'hFFFF_FFFF);
    check("hold_done", bus.done, 1'b0);

    // start while busy is ignored
    start_op(2'b00, 32'd2, 32'd3);
    n_done = 0; first = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        bus.start = 1'b1; bus.opcode = 2'b11; bus.a_input = 32'd9; bus.b_input = 32'd3;
      end
      if (c == 11) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        n_done++;
        if (first == 0) first = c;
      end
    end
    check("ign_ndone", n_done, 1);
    check("ign_lat", first, LAT);
    check("ign_lo", bus.lo, 32'd6);
    check("ign_hi", bus.hi, 32'd0);

    // Reset mid-operation aborts without a done pulse
    start_op(2'b00, 32'd7, 32'd9);
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    n_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    check("abort_ndone", n_done, 0);

`ifdef ALU_MULDIV_HILO_WR_EN
    @(negedge clk); bus.hi_we = 1'b1; bus.wr_data = 32'h0000_1234;
    @(posedge clk); #1; bus.hi_we = 1'b0;
    check("mthi_idle", bus.hi, 32'h0000_1234);
    check("mthi_nodone", bus.done, 1'b0);
    start_op(2'b00, 32'd2, 32'd3);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hDEAD_0000;
    @(posedge clk); #1; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mt_busy_hi", bus.hi, 32'h0000_1234);
    wait_done(lat, bok);
    check("mt_busy_lo", bus.lo, 32'd6);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 2'b01; bus.a_input = 32'd4; bus.b_input = 32'd5;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h0000_BEEF;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mt_start_hi", bus.hi, 32'd0);
    wait_done(lat, bok);
    check("mt_start_lat", lat, LAT);
    check("mt_start_lo", bus.lo, 32'd20);
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2, 3: b = 32'($urandom_range(1, 20));
        4: a = 32'h8000_0000;
        default: ;
      endcase
      model(op, a, b, mh, ml, md);
      start_op(op, a, b);
      wait_done(lat, bok);
      check($sformatf("rnd%0d_lat op%0d a=%h b=%h", i, op, a, b), lat, LAT);
      check($sformatf("rnd%0d_hi op%0d a=%h b=%h", i, op, a, b), bus.hi, mh);
      check($sformatf("rnd%0d_lo op%0d a=%h b=%h", i, op, a, b), bus.lo, ml);
      check($sformatf("rnd%0d_dbz op%0d a=%h b=%h", i, op, a, b), bus.div_by_zero, md);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit that runs beside the combinational ALU in the EX stage, generalising it to multi-cycle MIPS MULT/MULTU/DIV/DIVU with a parametrised operand width. The unit accepts one operation per start pulse and computes it over WIDTH+1 clock edges using a radix-2 shift-add/restoring-divide datapath. It holds the 2×WIDTH result in HI/LO registers and exposes busy/done so the hazard unit can stall on MFHI/MFLO.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 4.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  launch request; accepted only when busy=0
- opcode  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a_input  in  WIDTH  multiplicand / dividend
- b_input  in  WIDTH  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: hi/lo/div_by_zero valid and updated
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient
- div_by_zero  out  1  last completed op was DIV/DIVU with b_input=0

## Operation
- FSM states: IDLE, RUN, SIGN.
- IDLE: when start=1, latch opcode and operands, clear the iteration counter, and go to RUN. Signed ops latch magnitudes plus the result sign flags: product sign = a^b; quotient sign = a^b; remainder sign = a.
- RUN: one radix-2 step per cycle, exactly WIDTH steps. The counter runs 0..WIDTH-1 and the FSM enters SIGN after the step with count WIDTH-1.
- SIGN: apply two's-complement negation per the sign flags, write hi/lo/div_by_zero, pulse done, then return to IDLE.
- Multiply: hi:lo = full 2×WIDTH product. MULTU treats operands as unsigned.
- Divide: lo = quotient, truncated toward zero. hi = remainder, which takes the dividend's sign.
- Signed overflow: MIN / −1 gives lo=MIN, hi=0, with no flag.
- Divide by zero: the full latency is still used. Result is hi=a_input as latched, lo=all ones, div_by_zero=1.
- div_by_zero is cleared on completion of any other operation.
- start while busy=1 is ignored. The in-flight operation is unaffected.
- hi/lo hold their value between operations and change only at completion or reset.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0. Reset during RUN or SIGN aborts the operation with no done pulse.
- start sampled at edge N:
  - busy=1 from edge N until edge N+WIDTH+1.
  - At edge N+WIDTH+1, hi/lo update, done=1 for exactly one cycle, and busy=0.
  - Latency is WIDTH+1 cycles; for WIDTH=32 that is 33.
- Back-to-back: start may be asserted in the cycle done=1. That start is sampled at edge N+WIDTH+2, so the throughput is one op per WIDTH+2 cycles.
- done and busy are never high together.

## Configuration
- ALU_MULDIV_HILO_WR_EN defined:
  - Adds ports hi_we (in, 1), lo_we (in, 1) and wr_data (in, WIDTH) for MTHI/MTLO.
  - When busy=0 and start=0, hi_we/lo_we load wr_data into hi/lo at the clock edge. done does not pulse.
  - If start=1 in the same cycle, start has priority and the write is dropped.
  - While busy=1, writes are ignored.
  - Both writes may occur in the same cycle.
- Undefined: the ports do not exist, and hi/lo are written only by completed operations and reset.

## Test plan
- WIDTH=32, MULT a=−3 (FFFFFFFD), b=5 → done at start+33, hi=FFFFFFFF, lo=FFFFFFF1, div_by_zero=0.
- MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001. DIVU a=100, b=7 → lo=0000000E, hi=00000002.
- DIV a=−7, b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- DIV a=5, b=0 → after 33 cycles div_by_zero=1, hi=5, lo=FFFFFFFF. A following MULT 2×3 clears the flag: lo=6, hi=0.
- Start MULT 2×3, re-pulse start with DIVU 9/3 at cycle 10, then drop rst_n at no point → one done only, lo=6. Second run: pull rst_n low at cycle 20 → busy=0, hi=lo=0, and no done pulse ever.
- With ALU_MULDIV_HILO_WR_EN: write hi=1234 while idle → hi=1234 next cycle. Write asserted while busy → ignored. Write asserted together with start → ignored, and the op completes normally.
